// File: rtl/l1_sched_pkg.sv
// Shared types for the L1 trigger capture/readout schedulers.
package l1_sched_pkg;

    // Scheduler sequence: wait for a pending beam, capture, emit record, back off
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_RECORD,
        ST_HOLDOFF
    } sched_state_t;

    // Width of the saturating dropped-trigger counter
    localparam int DROP_W = 16;

endpackage

// File: rtl/l1_trigger_capture_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest requester wins last
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/l1_trigger_capture_scheduler.sv
// Latches per-beam L1 triggers, grants them round-robin, opens a fixed capture
// window per grant and then hands out one {beam, timestamp} event record.
module l1_trigger_capture_scheduler
    import l1_sched_pkg::*;
#(
    parameter int  NBEAMS      = 2,
    parameter int  CAPTURE_LEN = 64,
    parameter int  HOLDOFF     = 16,
    parameter int  TS_W        = 16,
    localparam int BIDX_W      = $clog2(NBEAMS)
) (
    input  logic                     aclk,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [NBEAMS-1:0]        beam_mask_i,
    input  logic [NBEAMS-1:0]        trig_i,
    output logic                     capture_o,
    output logic                     capture_last_o,
    output logic                     evt_tvalid_o,
    input  logic                     evt_tready_i,
    output logic [BIDX_W+TS_W-1:0]   evt_tdata_o,
    output logic [NBEAMS-1:0]        pending_o,
    output logic [DROP_W-1:0]        dropped_o,
    output logic                     busy_o
);

    localparam int CNT_MAX = (CAPTURE_LEN > HOLDOFF) ? CAPTURE_LEN : HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef struct packed {
        logic [BIDX_W-1:0] beam;
        logic [TS_W-1:0]   ts;
    } evt_t;

    sched_state_t       state;
    logic [CNT_W-1:0]   cnt;
    logic [TS_W-1:0]    ts;
    logic [BIDX_W-1:0]  rr_ptr;
    logic [BIDX_W-1:0]  gnt_idx;
    logic [NBEAMS-1:0]  gnt_oh;
    logic [NBEAMS-1:0]  clr;
    logic [NBEAMS-1:0]  new_trig;
    logic [NBEAMS-1:0]  drop_vec;
    logic [DROP_W:0]    drop_n;
    logic [DROP_W:0]    drop_sum;
    logic [DROP_W-1:0]  dropped_nxt;
    logic               fire;
    evt_t               evt;

    rr_arbiter #(.N(NBEAMS)) u_arb (
        .req   (pending_o),
        .ptr   (rr_ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx)
    );

    assign fire        = (state == ST_IDLE) && enable_i && (|pending_o);
    assign clr         = fire ? gnt_oh : '0;
    assign new_trig    = trig_i & beam_mask_i;
    // A retrigger on a beam being granted this cycle re-arms it instead of dropping
    assign drop_vec    = new_trig & pending_o & ~clr;
    assign evt_tdata_o = evt;

    // Count simultaneous drops and saturate the running total
    always_comb begin
        drop_n = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            drop_n = drop_n + (DROP_W + 1)'(drop_vec[b]);
        end
        drop_sum    = {1'b0, dropped_o} + drop_n;
        dropped_nxt = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    // Free-running timestamp, pending latch and drop counter
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            ts        <= '0;
            pending_o <= '0;
            dropped_o <= '0;
        end else begin
            ts        <= ts + 1'b1;
            pending_o <= (pending_o & ~clr) | new_trig;
            dropped_o <= dropped_nxt;
        end
    end

    // Grant / capture / record / holdoff sequencer with registered outputs
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            rr_ptr         <= '0;
            evt            <= '0;
            capture_o      <= 1'b0;
            capture_last_o <= 1'b0;
            evt_tvalid_o   <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        evt.beam       <= gnt_idx;
                        evt.ts         <= ts;
                        rr_ptr         <= (gnt_idx == BIDX_W'(NBEAMS - 1)) ? '0 : gnt_idx + 1'b1;
                        cnt            <= '0;
                        capture_o      <= 1'b1;
                        capture_last_o <= (CAPTURE_LEN == 1);
                        busy_o         <= 1'b1;
                        state          <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (cnt == CNT_W'(CAPTURE_LEN - 1)) begin
                        capture_o      <= 1'b0;
                        capture_last_o <= 1'b0;
                        evt_tvalid_o   <= 1'b1;
                        state          <= ST_RECORD;
                    end else begin
                        cnt            <= cnt + 1'b1;
                        capture_last_o <= (cnt == CNT_W'(CAPTURE_LEN - 2));
                    end
                end
                ST_RECORD: begin
                    if (evt_tready_i) begin
                        evt_tvalid_o <= 1'b0;
                        cnt          <= '0;
                        if (HOLDOFF == 0) begin
                            busy_o <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            state  <= ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == CNT_W'(HOLDOFF - 1)) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_trigger_capture_scheduler.sv
// Directed bench for l1_trigger_capture_scheduler (NBEAMS=2, CAPTURE_LEN=64, HOLDOFF=16).
// Cycle c is the interval after the c-th rising edge following reset release,
// so the timestamp during cycle c equals c.
module tb_l1_trigger_capture_scheduler;

    logic        aclk = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b1;
    logic [1:0]  beam_mask_i = 2'b11;
    logic [1:0]  trig_i = 2'b00;
    logic        evt_tready_i = 1'b1;
    logic        capture_o, capture_last_o, evt_tvalid_o, busy_o;
    logic [16:0] evt_tdata_o;
    logic [1:0]  pending_o;
    logic [15:0] dropped_o;

    int checks = 0;
    int errors = 0;
    int cyc;

    l1_trigger_capture_scheduler dut (
        .aclk           (aclk),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .beam_mask_i    (beam_mask_i),
        .trig_i         (trig_i),
        .capture_o      (capture_o),
        .capture_last_o (capture_last_o),
        .evt_tvalid_o   (evt_tvalid_o),
        .evt_tready_i   (evt_tready_i),
        .evt_tdata_o    (evt_tdata_o),
        .pending_o      (pending_o),
        .dropped_o      (dropped_o),
        .busy_o         (busy_o)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk or posedge reset_i) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge aclk);
    endtask

    task automatic pulse(input int c, input logic [1:0] v);
        goto(c);
        trig_i = v;
        @(negedge aclk);
        trig_i = 2'b00;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge aclk);
        reset_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        chk("rst_cap", capture_o, 0);
        chk("rst_last", capture_last_o, 0);
        chk("rst_valid", evt_tvalid_o, 0);
        chk("rst_data", evt_tdata_o, 0);
        chk("rst_pend", pending_o, 0);
        chk("rst_drop", dropped_o, 0);
        chk("rst_busy", busy_o, 0);

        // Single trigger on beam 0 in cycle 10
        do_reset();
        pulse(10, 2'b01);
        goto(11);
        chk("t1_pend", pending_o, 2'b01);
        chk("t1_busy11", busy_o, 0);
        for (int c = 11; c <= 76; c++) begin
            goto(c);
            chk("t1_cap", capture_o, (c >= 12 && c <= 75));
            chk("t1_last", capture_last_o, (c == 75));
        end
        chk("t1_valid", evt_tvalid_o, 1);
        chk("t1_data", evt_tdata_o, {1'b0, 16'd11});
        goto(77);
        chk("t1_valid77", evt_tvalid_o, 0);
        goto(92);
        chk("t1_busy92", busy_o, 1);
        goto(93);
        chk("t1_busy93", busy_o, 0);

        // Simultaneous triggers: round-robin order 0,1,0,1
        do_reset();
        pulse(10, 2'b11);
        goto(76);
        chk("t2_data_a", evt_tdata_o, {1'b0, 16'd11});
        goto(93);
        chk("t2_pend93", pending_o, 2'b10);
        chk("t2_cap93", capture_o, 0);
        goto(94);
        chk("t2_cap94", capture_o, 1);
        chk("t2_pend94", pending_o, 2'b00);
        goto(158);
        chk("t2_valid_b", evt_tvalid_o, 1);
        chk("t2_data_b", evt_tdata_o, {1'b1, 16'd93});
        pulse(180, 2'b11);
        goto(181);
        chk("t2_pend181", pending_o, 2'b11);
        goto(246);
        chk("t2_data_c", evt_tdata_o, {1'b0, 16'd181});
        goto(328);
        chk("t2_data_d", evt_tdata_o, {1'b1, 16'd263});

        // Drop counting and same-cycle grant + retrigger
        do_reset();
        pulse(10, 2'b01);
        pulse(20, 2'b10);
        pulse(30, 2'b10);
        pulse(40, 2'b10);
        pulse(50, 2'b10);
        goto(51);
        chk("t3_drop", dropped_o, 3);
        chk("t3_pend", pending_o, 2'b10);
        pulse(93, 2'b10);
        chk("t3_pend94", pending_o, 2'b10);
        chk("t3_drop94", dropped_o, 3);
        chk("t3_cap94", capture_o, 1);
        goto(158);
        chk("t3_data_a", evt_tdata_o, {1'b1, 16'd93});
        goto(176);
        chk("t3_cap176", capture_o, 1);
        goto(240);
        chk("t3_data_b", evt_tdata_o, {1'b1, 16'd175});
        chk("t3_drop240", dropped_o, 3);

        // Backpressure on the event record
        do_reset();
        evt_tready_i = 1'b0;
        pulse(10, 2'b01);
        goto(76);
        chk("t4_valid76", evt_tvalid_o, 1);
        chk("t4_data76", evt_tdata_o, {1'b0, 16'd11});
        pulse(80, 2'b10);
        goto(85);
        chk("t4_data85", evt_tdata_o, {1'b0, 16'd11});
        goto(95);
        chk("t4_valid95", evt_tvalid_o, 1);
        chk("t4_data95", evt_tdata_o, {1'b0, 16'd11});
        chk("t4_cap95", capture_o, 0);
        goto(96);
        evt_tready_i = 1'b1;
        goto(97);
        chk("t4_valid97", evt_tvalid_o, 0);
        chk("t4_busy97", busy_o, 1);
        goto(113);
        chk("t4_cap113", capture_o, 0);
        chk("t4_busy113", busy_o, 0);
        goto(114);
        chk("t4_cap114", capture_o, 1);
        chk("t4_data114", evt_tdata_o, {1'b1, 16'd113});

        // Mask and enable
        do_reset();
        beam_mask_i = 2'b10;
        pulse(10, 2'b01);
        chk("t5_pend_masked", pending_o, 2'b00);
        goto(12);
        chk("t5_busy12", busy_o, 0);
        beam_mask_i = 2'b11;
        pulse(20, 2'b01);
        goto(30);
        enable_i = 1'b0;
        pulse(40, 2'b10);
        goto(45);
        beam_mask_i = 2'b01;
        goto(50);
        chk("t5_pend50", pending_o, 2'b10);
        goto(85);
        chk("t5_cap85", capture_o, 1);
        chk("t5_last85", capture_last_o, 1);
        goto(86);
        chk("t5_cap86", capture_o, 0);
        chk("t5_valid86", evt_tvalid_o, 1);
        goto(110);
        chk("t5_busy110", busy_o, 0);
        chk("t5_pend110", pending_o, 2'b10);
        goto(120);
        chk("t5_cap120", capture_o, 0);
        enable_i = 1'b1;
        goto(121);
        chk("t5_cap121", capture_o, 1);
        chk("t5_data121", evt_tdata_o, {1'b1, 16'd120});
        beam_mask_i = 2'b11;

        // Asynchronous reset in the middle of a capture window
        do_reset();
        pulse(10, 2'b01);
        pulse(20, 2'b10);
        pulse(25, 2'b10);
        goto(41);
        chk("t6_cap41", capture_o, 1);
        chk("t6_drop41", dropped_o, 1);
        chk("t6_pend41", pending_o, 2'b10);
        #1 reset_i = 1'b1;
        #1;
        chk("t6_cap_rst", capture_o, 0);
        chk("t6_valid_rst", evt_tvalid_o, 0);
        chk("t6_pend_rst", pending_o, 0);
        chk("t6_drop_rst", dropped_o, 0);
        chk("t6_busy_rst", busy_o, 0);
        do_reset();
        pulse(5, 2'b01);
        goto(7);
        chk("t6_cap7", capture_o, 1);
        goto(71);
        chk("t6_valid71", evt_tvalid_o, 1);
        chk("t6_data71", evt_tdata_o, {1'b0, 16'd6});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
